// File: rtl/alu_rr_arbiter_if.sv
// Bundle of the request, ALU-side and response signals of alu_rr_arbiter.
// The slave modport is the arbiter view; master is the requester/ALU/consumer side.
interface alu_rr_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [10:0] req0_ctl;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [10:0] req1_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [10:0] alu_op_ctl;
  logic [31:0] alu_z;
  logic        alu_overflow;
  logic        alu_zero;
  logic        alu_carryout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_z;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic        rsp_carryout;
  logic        rsp_err;
  logic [31:0] op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctl,
    input  req1_valid, req1_a, req1_b, req1_ctl,
    input  alu_z, alu_overflow, alu_zero, alu_carryout,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op_ctl,
    output rsp_valid, rsp_id, rsp_z, rsp_overflow, rsp_zero, rsp_carryout, rsp_err,
    output op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctl,
    output req1_valid, req1_a, req1_b, req1_ctl,
    output alu_z, alu_overflow, alu_zero, alu_carryout,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op_ctl,
    input  rsp_valid, rsp_id, rsp_z, rsp_overflow, rsp_zero, rsp_carryout, rsp_err,
    input  op_count
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin sequencer sharing one external combinational ALU between two
// requesters: accept, hold operands for EXEC_CYCLES, capture, tagged response.
module alu_rr_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  alu_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 32'd1);

  state_t      r_state;
  logic        r_last_grant;
  logic [3:0]  r_cnt;
  logic        r_id;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [10:0] r_alu_op_ctl;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_z;
  logic        r_rsp_overflow;
  logic        r_rsp_zero;
  logic        r_rsp_carryout;
  logic        r_rsp_err;
  logic [31:0] r_op_count;

  logic        w_grant_id;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [10:0] w_sel_ctl;

  function automatic logic funct_is_legal(input logic [5:0] funct);
    logic ok;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100110, 6'b100101,
      6'b100111, 6'b000000, 6'b000010, 6'b101010, 6'b101011: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Grant selection and payload mux; on a tie the requester not served last wins.
  always_comb begin
    w_grant_id = 1'b0;
    w_ready0   = 1'b0;
    w_ready1   = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else if (bus.req1_valid) begin
      w_grant_id = 1'b1;
    end else begin
      w_grant_id = 1'b0;
    end
    // Ready is masked while rst_n is low so nothing is offered during reset.
    if (rst_n && (r_state == ST_IDLE) && (bus.req0_valid || bus.req1_valid)) begin
      w_ready0 = ~w_grant_id;
      w_ready1 = w_grant_id;
    end else begin
      w_ready0 = 1'b0;
      w_ready1 = 1'b0;
    end
    w_accept  = w_ready0 | w_ready1;
    w_sel_a   = w_grant_id ? bus.req1_a   : bus.req0_a;
    w_sel_b   = w_grant_id ? bus.req1_b   : bus.req0_b;
    w_sel_ctl = w_grant_id ? bus.req1_ctl : bus.req0_ctl;
    w_legal   = funct_is_legal(r_alu_op_ctl[5:0]);
  end

  // Sequencer FSM: issue, settle countdown, capture, and response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= 1'b1;
      r_cnt          <= 4'd0;
      r_id           <= 1'b0;
      r_alu_a        <= 32'd0;
      r_alu_b        <= 32'd0;
      r_alu_op_ctl   <= 11'd0;
      r_rsp_valid    <= 1'b0;
      r_rsp_z        <= 32'd0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_carryout <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_op_count     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_alu_op_ctl <= w_sel_ctl;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_cnt        <= CNT_LOAD;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == 4'd0) begin
            // Unsupported funct codes report zeros regardless of what the ALU drives.
            if (w_legal) begin
              r_rsp_z        <= bus.alu_z;
              r_rsp_overflow <= bus.alu_overflow;
              r_rsp_zero     <= bus.alu_zero;
              r_rsp_carryout <= bus.alu_carryout;
              r_rsp_err      <= 1'b0;
            end else begin
              r_rsp_z        <= 32'd0;
              r_rsp_overflow <= 1'b0;
              r_rsp_zero     <= 1'b0;
              r_rsp_carryout <= 1'b0;
              r_rsp_err      <= 1'b1;
            end
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 32'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready   = w_ready0;
  assign bus.req1_ready   = w_ready1;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_op_ctl   = r_alu_op_ctl;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_id;
  assign bus.rsp_z        = r_rsp_z;
  assign bus.rsp_overflow = r_rsp_overflow;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_carryout = r_rsp_carryout;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.op_count     = r_op_count;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a behavioural ALU feeds two instances (settle 1 and 4);
// a scoreboard queue holds expected responses pushed at accept, popped at handshake.
module tb_alu_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_rr_arbiter_if if1 ();
  alu_rr_arbiter_if if4 ();

  alu_rr_arbiter #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  alu_rr_arbiter #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [10:0] ctl;
    logic [31:0] z;
    logic        ovf;
    logic        zero;
    logic        cout;
    logic        err;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] z;
    logic        ovf;
    logic        zero;
    logic        cout;
    logic        err;
    int          acc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_count = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  int   acc_ids[$];
  exp_t exp_req[2];
  logic acc_flag[2];
  vec_t vecs[13];
  vec_t tie0;
  vec_t tie1;

  // Returns {overflow, zero, carryout, z}; unknown functs drive junk on purpose.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [10:0] ctl);
    logic [32:0] s;
    logic [31:0] z;
    logic        ovf;
    logic        cout;
    s = 33'd0; z = 32'd0; ovf = 1'b0; cout = 1'b0;
    case (ctl[5:0])
      6'h20: begin
        s = {1'b0, a} + {1'b0, b}; z = s[31:0]; cout = s[32];
        ovf = (a[31] == b[31]) && (z[31] != a[31]);
      end
      6'h22: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; z = s[31:0]; cout = s[32];
        ovf = (a[31] != b[31]) && (z[31] != a[31]);
      end
      6'h24: z = a & b;
      6'h25: z = a | b;
      6'h26: z = a ^ b;
      6'h27: z = ~(a | b);
      6'h00: z = a << ctl[10:6];
      6'h02: z = a >> ctl[10:6];
      6'h2A: z = {31'd0, ($signed(a) < $signed(b))};
      6'h2B: z = {31'd0, (a < b)};
      default: return {1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
    endcase
    return {ovf, (z == 32'd0), cout, z};
  endfunction

  always_comb {if1.alu_overflow, if1.alu_zero, if1.alu_carryout, if1.alu_z} =
      alu_model(if1.alu_a, if1.alu_b, if1.alu_op_ctl);
  always_comb {if4.alu_overflow, if4.alu_zero, if4.alu_carryout, if4.alu_z} =
      alu_model(if4.alu_a, if4.alu_b, if4.alu_op_ctl);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: monitor if1 at the falling edge, then return 1 time unit past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc_flag[0] = if1.req0_valid & if1.req0_ready;
    acc_flag[1] = if1.req1_valid & if1.req1_ready;
    for (int i = 0; i < 2; i++) begin
      if (acc_flag[i]) begin
        e = exp_req[i];
        e.acc = cyc + 1;
        sb.push_back(e);
        acc_ids.push_back(i);
      end
    end
    if (if1.rsp_valid && !prev_valid && (sb.size() > 0))
      check("latency", 64'(cyc - sb[0].acc), 64'd1);
    if (if1.rsp_valid && if1.rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id",       64'(if1.rsp_id),       64'(e.id));
        check("rsp_z",        64'(if1.rsp_z),        64'(e.z));
        check("rsp_overflow", 64'(if1.rsp_overflow), 64'(e.ovf));
        check("rsp_zero",     64'(if1.rsp_zero),     64'(e.zero));
        check("rsp_carryout", 64'(if1.rsp_carryout), 64'(e.cout));
        check("rsp_err",      64'(if1.rsp_err),      64'(e.err));
        exp_count++;
      end
    end
    prev_valid = if1.rsp_valid;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input vec_t v);
    exp_req[v.id] = '{v.id, v.z, v.ovf, v.zero, v.cout, v.err, 0};
    if (v.id == 1'b0) begin
      if1.req0_valid = 1'b1; if1.req0_a = v.a; if1.req0_b = v.b; if1.req0_ctl = v.ctl;
    end else begin
      if1.req1_valid = 1'b1; if1.req1_a = v.a; if1.req1_b = v.b; if1.req1_ctl = v.ctl;
    end
  endtask

  // Drop valid and scramble the payload so late sampling would corrupt the result.
  task automatic release_req(input logic id);
    if (id == 1'b0) begin
      if1.req0_valid = 1'b0; if1.req0_a = ~if1.req0_a; if1.req0_ctl = ~if1.req0_ctl;
    end else begin
      if1.req1_valid = 1'b0; if1.req1_a = ~if1.req1_a; if1.req1_ctl = ~if1.req1_ctl;
    end
  endtask

  task automatic issue(input vec_t v);
    logic got;
    int   n;
    got = 1'b0;
    n = 0;
    drive(v);
    while (!got && n < 20) begin
      step();
      got = acc_flag[v.id];
      n++;
    end
    check("accept", 64'(got), 64'd1);
    release_req(v.id);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] snap_z;
    logic        snap_id;

    rst_n = 1'b0;
    if1.req0_valid = 1'b0; if1.req0_a = 32'd0; if1.req0_b = 32'd0; if1.req0_ctl = 11'd0;
    if1.req1_valid = 1'b0; if1.req1_a = 32'd0; if1.req1_b = 32'd0; if1.req1_ctl = 11'd0;
    if1.rsp_ready  = 1'b1;
    if4.req0_valid = 1'b0; if4.req0_a = 32'd0; if4.req0_b = 32'd0; if4.req0_ctl = 11'd0;
    if4.req1_valid = 1'b0; if4.req1_a = 32'd0; if4.req1_b = 32'd0; if4.req1_ctl = 11'd0;
    if4.rsp_ready  = 1'b1;

    tie0 = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 11'h024, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0};
    tie1 = '{1'b1, 32'd5, 32'd7, 11'h022, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'h1,        11'h020, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'd5,        32'd7,        11'h022, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 11'h024, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'hAAAA5555, 32'hFFFF0000, 11'h026, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h12340000, 32'h00005678, 11'h025, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0,        32'h0,        11'h027, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h80000000, 32'h0,        11'h102, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'h1,        11'h02A, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'h1,        11'h02B, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h1234,     32'h5678,     11'h03F, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'h7FFFFFFF, 32'h1,        11'h020, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        32'h0,        11'h001, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 32'h3,        32'h0,        11'h040, 32'h6,        1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state, with both requesters already pending.
    drive(tie0);
    drive(tie1);
    step();
    step();
    check("rst_req0_ready", 64'(if1.req0_ready), 64'd0);
    check("rst_req1_ready", 64'(if1.req1_ready), 64'd0);
    check("rst_rsp_valid",  64'(if1.rsp_valid),  64'd0);
    check("rst_alu_a",      64'(if1.alu_a),      64'd0);
    check("rst_alu_b",      64'(if1.alu_b),      64'd0);
    check("rst_alu_op_ctl", 64'(if1.alu_op_ctl), 64'd0);
    check("rst_rsp_z",      64'(if1.rsp_z),      64'd0);
    check("rst_rsp_err",    64'(if1.rsp_err),    64'd0);
    check("rst_op_count",   64'(if1.op_count),   64'd0);

    // Tie arbitration: strict alternation 0,1,0 while both stay valid.
    rst_n = 1'b1;
    n = 0;
    while (acc_ids.size() < 3 && n < 40) begin
      step();
      n++;
    end
    release_req(1'b0);
    release_req(1'b1);
    check("tie_accepts", 64'(acc_ids.size()), 64'd3);
    if (acc_ids.size() >= 3) begin
      check("tie_grant0", 64'(acc_ids[0]), 64'd0);
      check("tie_grant1", 64'(acc_ids[1]), 64'd1);
      check("tie_grant2", 64'(acc_ids[2]), 64'd0);
    end
    drain();
    check("tie_op_count", 64'(if1.op_count), 64'd3);

    // Table of single operations, including illegal functs.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i]);
      drain();
      check("op_count", 64'(if1.op_count), 64'(exp_count));
    end

    // Backpressure: response held for 10 cycles while req1 waits.
    issue(vecs[4]);
    if1.rsp_ready = 1'b0;
    drive(tie1);
    n = 0;
    while (!if1.rsp_valid && n < 20) begin
      step();
      n++;
    end
    snap_z  = if1.rsp_z;
    snap_id = if1.rsp_id;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid",   64'(if1.rsp_valid),  64'd1);
      check("bp_rsp_z",       64'(if1.rsp_z),      64'(snap_z));
      check("bp_rsp_id",      64'(if1.rsp_id),     64'(snap_id));
      check("bp_req1_ready",  64'(if1.req1_ready), 64'd0);
      step();
    end
    if1.rsp_ready = 1'b1;
    step();
    check("bp_rsp_valid_low", 64'(if1.rsp_valid),  64'd0);
    check("bp_req1_ready_idle", 64'(if1.req1_ready), 64'd1);
    step();
    check("bp_req1_accept", 64'(acc_flag[1]), 64'd1);
    release_req(1'b1);
    drain();
    check("bp_op_count", 64'(if1.op_count), 64'(exp_count));

    // Settle interval 4 with an SLL by 31.
    if4.req0_valid = 1'b1; if4.req0_a = 32'd1; if4.req0_b = 32'd0; if4.req0_ctl = 11'h7C0;
    #1;
    check("sh_ready", 64'(if4.req0_ready), 64'd1);
    step();
    if4.req0_valid = 1'b0; if4.req0_a = 32'hFFFFFFFF; if4.req0_ctl = 11'h022;
    n = 0;
    while (!if4.rsp_valid && n < 20) begin
      check("sh_op_ctl", 64'(if4.alu_op_ctl), 64'h7C0);
      step();
      n++;
    end
    check("sh_latency", 64'(n), 64'd4);
    check("sh_rsp_z",   64'(if4.rsp_z),   64'h80000000);
    check("sh_rsp_id",  64'(if4.rsp_id),  64'd0);
    check("sh_rsp_err", 64'(if4.rsp_err), 64'd0);
    step();
    check("sh_op_count", 64'(if4.op_count), 64'd1);

    // Reset during EXEC drops the op.
    issue(vecs[0]);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid",  64'(if1.rsp_valid),  64'd0);
    check("mid_alu_a",      64'(if1.alu_a),      64'd0);
    check("mid_alu_b",      64'(if1.alu_b),      64'd0);
    check("mid_alu_op_ctl", 64'(if1.alu_op_ctl), 64'd0);
    check("mid_rsp_z",      64'(if1.rsp_z),      64'd0);
    check("mid_op_count",   64'(if1.op_count),   64'd0);
    check("mid_op_count4",  64'(if4.op_count),   64'd0);
    sb.delete();
    acc_ids.delete();
    exp_count = 0;
    prev_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_rsp", 64'(if1.rsp_valid), 64'd0);
    end
    check("mid_op_count_idle", 64'(if1.op_count), 64'd0);
    drive(tie0);
    drive(tie1);
    #1;
    check("mid_tie_req0", 64'(if1.req0_ready), 64'd1);
    check("mid_tie_req1", 64'(if1.req1_ready), 64'd0);
    step();
    release_req(1'b0);
    release_req(1'b1);
    drain();
    check("mid_op_count_after", 64'(if1.op_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one combinational `ALU_32` between two requesters. It accepts one operation at a time through a valid/ready request port. It registers the operands onto the ALU, waits a programmable settle interval, and captures the result and flags. It then returns them on a single tagged response port with backpressure. It sits between the requesting units and the `ALU_32` instance; it does not contain the ALU.

## Interface
- `EXEC_CYCLES`, 1: cycles ALU inputs are held before capture; legal range 1–15.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high with valid.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  operands.
- `req0_ctl` / `req1_ctl`  in  11  `[10:6]` shamt, `[5:0]` funct (ALU encoding).
- `alu_a`, `alu_b`  out  32  to ALU `A`, `B`.
- `alu_op_ctl`  out  11  to ALU `op_ctl`.
- `alu_z`  in  32  from ALU `Z`.
- `alu_overflow`, `alu_zero`, `alu_carryout`  in  1  from ALU flags.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester index of response.
- `rsp_z`  out  32  captured result.
- `rsp_overflow`, `rsp_zero`, `rsp_carryout`  out  1  captured flags.
- `rsp_err`  out  1  funct code unsupported.
- `op_count`  out  32  completed responses, wraps modulo 2^32.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `reqN_ready` is high only for the granted requester. It is driven combinationally from the valids and `last_grant`.
  - Grant rule: only one valid means that one is granted. If both are valid, the requester ≠ `last_grant` is granted.
  - On accept: register the operands and ctl into `alu_a`/`alu_b`/`alu_op_ctl`, latch the id, set `last_grant` = id, load the settle counter with `EXEC_CYCLES-1`, and go to EXEC.
- **EXEC**
  - Counter decrements each cycle.
  - In the cycle the counter is 0, capture `alu_z` and the flags into the `rsp_*` registers, then go to RESP.
- **RESP**
  - `rsp_valid` = 1 and all `rsp_*` fields are stable.
  - On `rsp_valid & rsp_ready`: increment `op_count`, then go to IDLE.
  - `reqN_ready` = 0 in EXEC and RESP.
- **Legal funct codes**
  - 100000 ADD, 100010 SUB, 100100 AND, 100110 XOR, 100101 OR, 100111 NOR.
  - 000000 SLL, 000010 SRL, 101010 SLT, 101011 SLTU.
- **Illegal funct**
  - The op still passes through EXEC, so latency is unchanged.
  - Captured `rsp_z` = 0, all flags = 0, `rsp_err` = 1.
- `rsp_err` = 0 for legal ops.
- `alu_*` outputs hold their last issued values while idle, so there is no toggling on the ALU between ops.

## Timing
- **Reset values:** state IDLE, `last_grant` = 1 (req0 wins the first tie), `alu_a` = `alu_b` = 0, `alu_op_ctl` = 0.
- All `rsp_*` = 0, `rsp_valid` = 0, `op_count` = 0. Both `reqN_ready` = 0 during reset.
- **Latency:** accept at edge N means EXEC occupies N..N+`EXEC_CYCLES`-1, and `rsp_valid` rises after edge N+`EXEC_CYCLES`.
  - With `EXEC_CYCLES` = 1, `rsp_valid` is high in the cycle after the EXEC cycle.
- **Throughput:** at most one op per `EXEC_CYCLES`+2 cycles (IDLE, EXEC..., RESP). No accept in the response handshake cycle.
- **Backpressure:** `rsp_ready` low holds RESP indefinitely. Requests stay unaccepted and requesters must hold valid and operands.
- **Request stability:** the request payload is sampled only on the accept edge. Changes after accept have no effect.
- **Simultaneous valid:** strict alternation 0,1,0,1 while both remain valid. There is no starvation.
- **Asynchronous reset mid-operation** (EXEC or RESP):
  - Immediate return to IDLE with all outputs at reset values.
  - The in-flight op is dropped, with no response and no `op_count` increment.
- **`op_count` at 0xFFFFFFFF** wraps to 0 on the next completed response.

## Test plan
- **Single op:** req0 ADD, A=0xFFFFFFFF, B=1, `EXEC_CYCLES`=1, `rsp_ready`=1. Expect:
  - `rsp_valid` 2 edges after accept.
  - `rsp_id`=0, `rsp_z`=0, `rsp_zero`=1, `rsp_carryout`=1, `rsp_err`=0, `op_count`=1.
- **Tie arbitration:** after reset, req0 and req1 both valid continuously (req0 AND 0xF0F0F0F0&0xFF00FF00, req1 SUB 5−7). Expect:
  - Responses in order id 0 (`rsp_z`=0xF000F000), then id 1 (`rsp_z`=0xFFFFFFFE).
  - Third grant goes to req0 if it is re-asserted.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles with req1 valid. Expect:
  - `rsp_valid` and fields stable throughout, `req1_ready`=0 throughout.
  - When `rsp_ready`=1, the handshake completes, the next cycle is IDLE, and req1 is accepted.
- **Illegal op:** req1 ctl = 11'h03F. Expect `rsp_err`=1, `rsp_z`=0, flags 0, same latency as a legal op.
- **Settle interval and shift:** `EXEC_CYCLES`=4, req0 SLL A=1, shamt=31. Expect:
  - `alu_op_ctl`=11'h7C0 for 4 cycles.
  - `rsp_valid` 5 edges after accept, `rsp_z`=0x80000000.
- **Reset mid-op:** drop `rst_n` during EXEC. Expect:
  - All outputs at reset values asynchronously, no response after release, `op_count`=0.
  - Next request is served normally with req0 winning a tie.
